shift_add_multiplier: RTL and testbench

- Iterative unsigned multiplier. Sits directly upstream and downstream of the 64-bit adder: it drives the adder's operand1/operand2/cin and consumes its result every cycle.
- Produces a 2*WIDTH-bit product from two WIDTH-bit operands, one shift-add step per cycle.
- Stops as soon as the remaining multiplier bits are all zero.
- Start/busy/done handshake toward the controlling logic.

---
 rtl/shift_add_multiplier_if.sv | 30 +++
 rtl/shift_add_multiplier.sv | 85 ++++++++
 tb/tb_shift_add_multiplier.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_if.sv
// Bus bundle for the iterative multiplier: the start/busy/done control side and
// the operand/result wires that loop through the external adder.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 32
);
    // Handshake: the controller raises start with operands valid; it is taken on
    // any rising edge where busy is low. done with product valid holds until the next
    // accepted start. The adder must produce add_result combinationally.
    logic                 start;
    logic [WIDTH-1:0]     mult_op1;
    logic [WIDTH-1:0]     mult_op2;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   add_op1;
    logic [2*WIDTH-1:0]   add_op2;
    logic                 add_cin;
    logic [2*WIDTH-1:0]   add_result;
    logic                 add_cout;

    modport master (
        output start, mult_op1, mult_op2, add_result, add_cout,
        input  busy, done, product, add_op1, add_op2, add_cin
    );

    modport slave (
        input  start, mult_op1, mult_op2, add_result, add_cout,
        output busy, done, product, add_op1, add_op2, add_cin
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Unsigned shift-add multiplier: one partial product per cycle through an external
// adder, finishing early once the remaining multiplier bits are all zero.
module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    shift_add_multiplier_if.slave bus,
    output logic [1:0]            dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplr;
    logic                 accept;
    logic                 unused_cout;

    assign accept      = (state != BUSY) && bus.start;
    assign unused_cout = bus.add_cout;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = (bus.mult_op2 == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                // Stop once the bits still to be consumed after this step are zero.
                if (mplr[WIDTH-1:1] == '0) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            BUSY:    bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
        end else if (accept) begin
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, bus.mult_op1};
            mplr  <= bus.mult_op2;
        end else if (state == BUSY) begin
            acc   <= bus.add_result;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
        end
    end

    assign bus.add_op1 = acc;
    assign bus.add_op2 = mplr[0] ? mcand : '0;
    assign bus.add_cin = 1'b0;
    assign bus.product = acc;
    assign dbg_state   = state;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: table vectors, random operands
// against an arithmetic reference, and hand-written handshake corner cases.
module tb_shift_add_multiplier;
  localparam int W = 32;

  logic clk;
  logic resetn;
  logic [1:0] dbg_state;
  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  shift_add_multiplier_if #(.WIDTH(W)) bus ();

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // behavioural adder sitting on the loop
  assign {bus.add_cout, bus.add_result} = {1'b0, bus.add_op1} + {1'b0, bus.add_op2} + {{(2*W){1'b0}}, bus.add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   op1;
    logic [W-1:0]   op2;
    logic [2*W-1:0] prod;
    int             lat;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] a64;
    logic [2*W-1:0] b64;
    a64 = {{W{1'b0}}, a};
    b64 = {{W{1'b0}}, b};
    return a64 * b64;
  endfunction

  // edges after the start edge until done shows: 1 + index of highest set bit, 0 if none
  function automatic int ref_lat(input logic [W-1:0] b);
    int k;
    k = 0;
    for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
    return k;
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2*W-1:0] prod, output int lat, output int bcnt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mult_op1 = a;
    bus.mult_op2 = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.done) check("done_timeout", 64'(lat), 64'(ref_lat(b)));
    prod = bus.product;
  endtask

  task automatic run_and_score(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2*W-1:0] exp_p, input int exp_lat);
    logic [2*W-1:0] p;
    int lat;
    int bcnt;
    exp_q.push_back(exp_p);
    run_op(a, b, p, lat, bcnt);
    check({name, "_product"}, p, exp_q.pop_front());
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat));
  endtask

  initial begin
    logic [2*W-1:0] p;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int lat;
    int bcnt;
    int n;
    bit hold_ok;

    vecs[0] = '{op1: 32'd7,          op2: 32'd9,          prod: 64'h3F,               lat: 4};
    vecs[1] = '{op1: 32'hFFFF_FFFF,  op2: 32'hFFFF_FFFF,  prod: 64'hFFFFFFFE00000001, lat: 32};
    vecs[2] = '{op1: 32'h1234_5678,  op2: 32'd0,          prod: 64'h0,                lat: 0};
    vecs[3] = '{op1: 32'd6,          op2: 32'd7,          prod: 64'd42,               lat: 3};
    vecs[4] = '{op1: 32'd0,          op2: 32'h80,         prod: 64'h0,                lat: 8};
    vecs[5] = '{op1: 32'hDEAD_BEEF,  op2: 32'd1,          prod: 64'hDEADBEEF,         lat: 1};

    // reset
    resetn = 1'b0;
    bus.start = 1'b0;
    bus.mult_op1 = '0;
    bus.mult_op2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_product", bus.product, 64'd0);
    check("reset_add_op1", bus.add_op1, 64'd0);
    check("reset_add_op2", bus.add_op2, 64'd0);
    check("reset_add_cin", 64'(bus.add_cin), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_done", 64'(bus.done), 64'd0);

    // table vectors
    for (int i = 0; i < 6; i++) begin
      run_and_score($sformatf("vec%0d", i), vecs[i].op1, vecs[i].op2, vecs[i].prod, vecs[i].lat);
    end

    // product and done hold while idle after 7*9
    run_and_score("hold", 32'd7, 32'd9, 64'h3F, 4);
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!bus.done || bus.product !== 64'h3F || bus.busy) hold_ok = 1'b0;
    end
    check("hold_10_cycles", 64'(hold_ok), 64'd1);

    // random operands against the reference model
    for (int i = 0; i < 25; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (i % 5 == 0) ra = ra >> $urandom_range(0, 31);
      run_and_score($sformatf("rand%0d", i), ra, rb, ref_prod(ra, rb), ref_lat(rb));
    end

    // start during BUSY is ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.mult_op1 = 32'd3;
    bus.mult_op2 = 32'h8000_0000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.mult_op1 = 32'd5;
    bus.mult_op2 = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 2;
    while (!bus.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ignore_start_latency", 64'(n), 64'd32);
    check("ignore_start_product", bus.product, 64'h1_8000_0000);

    // reset mid-operation aborts immediately
    @(negedge clk);
    bus.start = 1'b1;
    bus.mult_op1 = 32'hFFFF;
    bus.mult_op2 = 32'hFFFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_abort_busy", 64'(bus.busy), 64'd1);
    resetn = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_product", bus.product, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_and_score("after_abort", 32'd6, 32'd7, 64'd42, 3);

    // back-to-back with start held high from DONE
    @(negedge clk);
    bus.start = 1'b1;
    bus.mult_op1 = 32'd2;
    bus.mult_op2 = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    check("b2b_first_done", 64'(bus.done), 64'd1);
    check("b2b_first_product", bus.product, 64'd6);
    bus.mult_op1 = 32'd4;
    bus.mult_op2 = 32'd1;
    @(posedge clk);
    #1;
    check("b2b_done_dropped", 64'(bus.done), 64'd0);
    check("b2b_no_idle", 64'(bus.busy), 64'd1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("b2b_second_done", 64'(bus.done), 64'd1);
    check("b2b_second_product", bus.product, 64'd4);
    @(posedge clk);
    #1;
    check("b2b_done_holds", 64'(bus.done), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
